// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port dRam between the processor (p) and the host loader (h) over req/ack.
// Optional DRAM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed processor priority.
module dram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ack,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_ctrl,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  // state | meaning
  // IDLE  | sample requests, latch the winner's operands
  // ISSUE | drive one read or write command to dRam
  // WAIT  | count down read latency, capture data on 1->0
  // DONE  | pulse the owner's ack
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic       lat_we;
  logic [2:0] lat_cnt;
  logic       grant_h;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic last_served;

  // On contention the port that did not win last time goes next.
  assign grant_h = h_req & (~p_req | ~last_served);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
    end else if (state == IDLE && (p_req || h_req)) begin
      last_served <= grant_h;
    end
  end
`else
  assign grant_h = h_req & ~p_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ctrl  <= 2'b00;
      p_ack     <= 1'b0;
      h_ack     <= 1'b0;
      p_rdata   <= '0;
      h_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      p_ack <= 1'b0;
      h_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p_req || h_req) begin
            owner <= grant_h;
            busy  <= 1'b1;
            state <= ISSUE;
            // mem_addr/mem_wdata double as the operand latches; mem_ctrl alone qualifies them.
            if (grant_h) begin
              lat_we    <= h_we;
              mem_addr  <= h_addr;
              mem_wdata <= h_wdata;
              mem_ctrl  <= h_we ? 2'b10 : 2'b01;
            end else begin
              lat_we    <= p_we;
              mem_addr  <= p_addr;
              mem_wdata <= p_wdata;
              mem_ctrl  <= p_we ? 2'b10 : 2'b01;
            end
          end
        end
        ISSUE: begin
          mem_ctrl <= 2'b00;
          if (lat_we) begin
            p_ack <= ~owner;
            h_ack <= owner;
            state <= DONE;
          end else begin
            lat_cnt <= 3'(RD_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (owner) h_rdata <= mem_rdata;
            else       p_rdata <= mem_rdata;
            p_ack <= ~owner;
            h_ack <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: latency-accurate dRam model plus a queue-based reference for grant order and data.
// Expectations follow DRAM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dram_arbiter;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [18:0] p_addr = '0, h_addr = '0;
  logic [7:0]  p_wdata = '0, h_wdata = '0;
  logic        p_ack, h_ack, busy, owner;
  logic [7:0]  p_rdata, h_rdata, mem_wdata, mem_rdata;
  logic [18:0] mem_addr;
  logic [1:0]  mem_ctrl;

  int n_checks = 0;
  int n_pass = 0;

  dram_arbiter #(.ADDR_W(19), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_ack(p_ack), .p_rdata(p_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [18:0] a);
    return (a == 19'h7FFFF) ? 8'h3C : (a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A);
  endfunction

  // dRam model: read data is valid only in the cycle RD_LAT-1 cycles after the command cycle's edge
  bit [7:0] dram   [0:524287];
  bit       dvalid [0:524287];
  bit [2:0] rd_cnt;
  bit [7:0] rd_val;
  always @(posedge clk) begin
    if (mem_ctrl == 2'b10) begin
      dram[mem_addr]   <= mem_wdata;
      dvalid[mem_addr] <= 1'b1;
    end
    if (mem_ctrl == 2'b01) begin
      rd_cnt <= 3'(RD_LAT);
      rd_val <= dvalid[mem_addr] ? dram[mem_addr] : dflt(mem_addr);
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 3'd1;
    end
  end
  assign mem_rdata = (rd_cnt == 3'd1) ? rd_val : 8'hEE;

  // reference state
  bit [7:0] ref_mem   [0:524287];
  bit       ref_valid [0:524287];
  logic [7:0] exp_prd, exp_hrd;
  bit got_order[$];
  int got_cyc[$];
  bit exp_order[$];

  function automatic logic [7:0] exp_read(input logic [18:0] a);
    return ref_valid[a] ? ref_mem[a] : dflt(a);
  endfunction

  task automatic ref_write(input logic [18:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    ref_valid[a] = 1'b1;
  endtask

  // grant order from the arbitration rules, assuming both ports re-request immediately after each ack
  task automatic model_order(input int np, input int nh);
    int pl = np;
    int hl = nh;
    bit last = 1'b1;
    bit pick;
    exp_order.delete();
    while (pl > 0 || hl > 0) begin
      if (pl > 0 && hl > 0) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        pick = ~last;
`else
        pick = 1'b0;
`endif
      end else begin
        pick = (pl > 0) ? 1'b0 : 1'b1;
      end
      exp_order.push_back(pick);
      last = pick;
      if (pick) hl--; else pl--;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    p_req = 1'b0;
    h_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_prd = 8'h00;
    exp_hrd = 8'h00;
    @(posedge clk);
    #1;
  endtask

  // One access from an idle arbiter; cycle 0 is the IDLE cycle in which req is first seen.
  task automatic access(input bit port, input bit we, input logic [18:0] addr, input logic [7:0] wdata,
                        output int issue_cyc, output logic [1:0] issue_ctrl, output logic [18:0] issue_addr,
                        output logic [7:0] issue_data, output int ctrl_cycles, output int ack_cyc,
                        output bit wrong_ack, output logic [7:0] rd_p, output logic [7:0] rd_h);
    issue_cyc = -1; ack_cyc = -1; ctrl_cycles = 0; wrong_ack = 1'b0;
    issue_ctrl = 2'b00; issue_addr = '0; issue_data = '0; rd_p = '0; rd_h = '0;
    if (port == 1'b0) begin
      p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata;
    end else begin
      h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata;
    end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (mem_ctrl != 2'b00) begin
        ctrl_cycles++;
        if (issue_cyc < 0) begin
          issue_cyc = c; issue_ctrl = mem_ctrl; issue_addr = mem_addr; issue_data = mem_wdata;
        end
      end
      if (port ? p_ack : h_ack) wrong_ack = 1'b1;
      if (port ? h_ack : p_ack) begin
        ack_cyc = c; rd_p = p_rdata; rd_h = h_rdata;
        break;
      end
    end
    p_req = 1'b0;
    h_req = 1'b0;
    @(posedge clk);
    #1;
    if (we) ref_write(addr, wdata);
  endtask

  // Both ports stream writes with req held; acked accesses are replaced by new operands.
  task automatic run_stream(input int np, input int nh);
    int pl = np;
    int hl = nh;
    got_order.delete();
    got_cyc.delete();
    p_we = 1'b1; h_we = 1'b1;
    p_addr = 19'(32'h200 + $urandom_range(0, 63)); p_wdata = 8'($urandom);
    h_addr = 19'(32'h300 + $urandom_range(0, 63)); h_wdata = 8'($urandom);
    p_req = (pl > 0);
    h_req = (hl > 0);
    for (int c = 1; c <= 400 && (pl > 0 || hl > 0); c++) begin
      @(posedge clk);
      #1;
      if (p_ack) begin
        got_order.push_back(1'b0); got_cyc.push_back(c);
        ref_write(p_addr, p_wdata);
        pl--;
        if (pl == 0) p_req = 1'b0;
        else begin p_addr = 19'(32'h200 + $urandom_range(0, 63)); p_wdata = 8'($urandom); end
      end
      if (h_ack) begin
        got_order.push_back(1'b1); got_cyc.push_back(c);
        ref_write(h_addr, h_wdata);
        hl--;
        if (hl == 0) h_req = 1'b0;
        else begin h_addr = 19'(32'h300 + $urandom_range(0, 63)); h_wdata = 8'($urandom); end
      end
    end
    p_req = 1'b0;
    h_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    n_checks++;
    if (mem_ctrl !== 2'b00 || mem_addr !== 19'd0 || mem_wdata !== 8'd0)
      $display("FAIL reset_mem: ctrl=%b addr=%h wdata=%h, required 00/0/0", mem_ctrl, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if (p_ack !== 1'b0 || h_ack !== 1'b0 || p_rdata !== 8'd0 || h_rdata !== 8'd0)
      $display("FAIL reset_ports: p_ack=%b h_ack=%b p_rdata=%h h_rdata=%h, required all 0", p_ack, h_ack, p_rdata, h_rdata);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || owner !== 1'b0)
      $display("FAIL reset_status: busy=%b owner=%b, required 0/0", busy, owner);
    else n_pass++;
    reset_dut();
  endtask

  task automatic test_p_write();
    int ic, cc, ac; logic [1:0] ictl; logic [18:0] ia; logic [7:0] id, rp, rh; bit wa;
    access(1'b0, 1'b1, 19'h00010, 8'hA5, ic, ictl, ia, id, cc, ac, wa, rp, rh);
    n_checks++;
    if (ic !== 1 || ictl !== 2'b10 || ia !== 19'h00010 || id !== 8'hA5)
      $display("FAIL p_write_issue: cyc=%0d ctrl=%b addr=%h data=%h, required 1/10/00010/a5", ic, ictl, ia, id);
    else n_pass++;
    n_checks++;
    if (ac !== 2) $display("FAIL p_write_ack: ack cycle %0d, required 2", ac);
    else n_pass++;
    n_checks++;
    if (wa !== 1'b0 || cc !== 1) $display("FAIL p_write_quiet: h_ack seen=%b cmd cycles=%0d, required 0/1", wa, cc);
    else n_pass++;
  endtask

  task automatic test_h_read_boundary();
    int ic, cc, ac; logic [1:0] ictl; logic [18:0] ia; logic [7:0] id, rp, rh; bit wa;
    access(1'b1, 1'b0, 19'h7FFFF, 8'h00, ic, ictl, ia, id, cc, ac, wa, rp, rh);
    n_checks++;
    if (ic !== 1 || ictl !== 2'b01 || ia !== 19'h7FFFF || cc !== 1)
      $display("FAIL h_read_issue: cyc=%0d ctrl=%b addr=%h cmd cycles=%0d, required 1/01/7ffff/1", ic, ictl, ia, cc);
    else n_pass++;
    n_checks++;
    if (ac !== 2 + RD_LAT) $display("FAIL h_read_ack: ack cycle %0d, required %0d", ac, 2 + RD_LAT);
    else n_pass++;
    n_checks++;
    if (rh !== 8'h3C || rp !== 8'h00 || wa !== 1'b0)
      $display("FAIL h_read_data: h_rdata=%h p_rdata=%h p_ack seen=%b, required 3c/00/0", rh, rp, wa);
    else n_pass++;
    n_checks++;
    if (owner !== 1'b1) $display("FAIL h_read_owner: owner=%b, required 1", owner);
    else n_pass++;
    exp_hrd = 8'h3C;
  endtask

  task automatic test_random();
    int ic, cc, ac, sel; logic [1:0] ictl; logic [18:0] ia, addr; logic [7:0] id, rp, rh, wd, ev; bit wa, port, we;
    for (int i = 0; i < 24; i++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 3);
      addr = (sel == 0) ? 19'h00000 : (sel == 1) ? 19'h7FFFE : 19'(32'h100 + $urandom_range(0, 5));
      wd   = 8'($urandom);
      ev   = exp_read(addr);
      access(port, we, addr, wd, ic, ictl, ia, id, cc, ac, wa, rp, rh);
      n_checks++;
      if (ic !== 1 || ia !== addr || ictl !== (we ? 2'b10 : 2'b01) || (we && id !== wd) || cc !== 1)
        $display("FAIL rand_issue[%0d]: cyc=%0d ctrl=%b addr=%h data=%h, required 1/%b/%h/%h", i, ic, ictl, ia, id, we ? 2'b10 : 2'b01, addr, wd);
      else n_pass++;
      n_checks++;
      if (ac !== (we ? 2 : 2 + RD_LAT) || wa !== 1'b0)
        $display("FAIL rand_ack[%0d]: ack cycle %0d wrong-port ack=%b, required %0d/0", i, ac, wa, we ? 2 : 2 + RD_LAT);
      else n_pass++;
      if (!we) begin
        if (port) exp_hrd = ev; else exp_prd = ev;
      end
      n_checks++;
      if (rp !== exp_prd || rh !== exp_hrd)
        $display("FAIL rand_rdata[%0d]: p_rdata=%h h_rdata=%h, required %h/%h", i, rp, rh, exp_prd, exp_hrd);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0, issues = 0, ack1 = -1, ack2 = -1, iss2 = -1;
    logic [18:0] iss2_addr = '0;
    logic [7:0] r1 = '0, r2 = '0, e1, e2;
    e1 = exp_read(19'h00001);
    e2 = exp_read(19'h00002);
    p_req = 1'b1; p_we = 1'b0; p_addr = 19'h00001;
    for (int c = 0; c < 60 && acks < 2; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (mem_ctrl != 2'b00) begin
        issues++;
        if (issues == 2) begin iss2 = c; iss2_addr = mem_addr; end
      end
      if (p_ack) begin
        acks++;
        if (acks == 1) begin ack1 = c; r1 = p_rdata; p_addr = 19'h00002; end
        else begin ack2 = c; r2 = p_rdata; p_req = 1'b0; end
      end
    end
    p_req = 1'b0;
    @(posedge clk);
    #1;
    exp_prd = e2;
    n_checks++;
    if (ack1 !== 2 + RD_LAT || r1 !== e1)
      $display("FAIL b2b_first: ack cycle %0d rdata=%h, required %0d/%h", ack1, r1, 2 + RD_LAT, e1);
    else n_pass++;
    n_checks++;
    if (iss2 !== ack1 + 2 || iss2_addr !== 19'h00002)
      $display("FAIL b2b_issue2: cycle %0d addr=%h, required %0d/00002", iss2, iss2_addr, ack1 + 2);
    else n_pass++;
    n_checks++;
    if (ack2 !== ack1 + 3 + RD_LAT || r2 !== e2)
      $display("FAIL b2b_second: ack cycle %0d rdata=%h, required %0d/%h", ack2, r2, ack1 + 3 + RD_LAT, e2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int ic, cc, ac; logic [1:0] ictl; logic [18:0] ia; logic [7:0] id, rp, rh; bit wa, seen_ack = 1'b0;
    // reset while the write command is on the bus
    p_req = 1'b1; p_we = 1'b1; p_addr = 19'h00077; p_wdata = 8'h11;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_ctrl !== 2'b00 || busy !== 1'b0)
      $display("FAIL rst_issue_async: ctrl=%b busy=%b, required 00/0", mem_ctrl, busy);
    else n_pass++;
    p_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // reset in the WAIT state of a read
    p_req = 1'b1; p_we = 1'b0; p_addr = 19'h00055;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_ctrl !== 2'b00 || busy !== 1'b0 || p_ack !== 1'b0)
      $display("FAIL rst_wait_async: ctrl=%b busy=%b p_ack=%b, required 00/0/0", mem_ctrl, busy, p_ack);
    else n_pass++;
    p_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (p_ack || h_ack) seen_ack = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    exp_prd = 8'h00; exp_hrd = 8'h00;
    @(posedge clk);
    #1;
    for (int c = 0; c < RD_LAT + 3; c++) begin
      if (p_ack || h_ack) seen_ack = 1'b1;
      if (c < RD_LAT + 2) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (seen_ack !== 1'b0) $display("FAIL rst_no_ack: ack seen=%b after reset, required 0", seen_ack);
    else n_pass++;
    access(1'b1, 1'b1, 19'h00123, 8'h9E, ic, ictl, ia, id, cc, ac, wa, rp, rh);
    n_checks++;
    if (ac !== 2 || ictl !== 2'b10 || ia !== 19'h00123 || wa !== 1'b0)
      $display("FAIL rst_then_h_write: ack cycle %0d ctrl=%b addr=%h p_ack=%b, required 2/10/00123/0", ac, ictl, ia, wa);
    else n_pass++;
  endtask

  task automatic check_stream(input string name, input int np, input int nh);
    model_order(np, nh);
    n_checks++;
    if (got_order.size() !== exp_order.size())
      $display("FAIL %s_count: %0d grants, required %0d", name, got_order.size(), exp_order.size());
    else n_pass++;
    for (int i = 0; i < got_order.size() && i < exp_order.size(); i++) begin
      n_checks++;
      if (got_order[i] !== exp_order[i])
        $display("FAIL %s_order[%0d]: port %0d, required %0d", name, i, got_order[i], exp_order[i]);
      else n_pass++;
      n_checks++;
      if (got_cyc[i] !== 2 + 3 * i)
        $display("FAIL %s_cycle[%0d]: ack cycle %0d, required %0d", name, i, got_cyc[i], 2 + 3 * i);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    reset_dut();
    run_stream(1, 1);
    check_stream("contend", 1, 1);
  endtask

  task automatic test_alternation();
    reset_dut();
    run_stream(4, 4);
    check_stream("alternate", 4, 4);
  endtask

  task automatic test_starvation();
    int first_h = -1;
    reset_dut();
    run_stream(10, 3);
    check_stream("starve", 10, 3);
    foreach (got_order[i]) if (got_order[i] && first_h < 0) first_h = i;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    n_checks++;
    if (first_h < 0 || first_h > 1) $display("FAIL starve_host_rr: first host grant index %0d, required <= 1", first_h);
    else n_pass++;
`else
    n_checks++;
    if (first_h !== 10) $display("FAIL starve_host_fixed: first host grant index %0d, required 10", first_h);
    else n_pass++;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_prd = 8'h00;
    exp_hrd = 8'h00;
    test_reset();
    test_p_write();
    test_h_read_boundary();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
    test_contention();
    test_alternation();
    test_starvation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
